instr_fetch: RTL and testbench

- Upstream neighbour of the decoder: owns the fetch program counter, issues one instruction-memory read per decoder fetch request, and presents a stable 32-bit instruction word plus its PC.
- Accepts PC redirects (taken branch / JAL / JALR) from the execute stage.
- Holds the instruction steady until the next fetch is accepted, so the decoder can sample instr across its DECODE/OP states.

---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/instr_fetch_watchdog.sv | 26 ++
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types and defaults: state encoding, reset PC, NOP word, timeout limit.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_ST_IDLE = 2'd0,
    FETCH_ST_REQ  = 2'd1,
    FETCH_ST_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_VAL       = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_VAL      = 32'h0000_0013;
  localparam int          TIMEOUT_CYCLES_DEF = 16;

  // Instruction fetches are always word aligned; low bits are dropped, never trapped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_watchdog.sv
// Stall counter for an outstanding fetch; o_expired pulses on the stall cycle that hits LIMIT.
module instr_fetch_watchdog #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_count) begin
      r_count <= r_count + CW'(1);
    end
  end

  // The current stall cycle is number r_count+1, so expiry fires when it equals LIMIT.
  assign o_expired = i_count && (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one memory read per fetch_stage high period, PC redirects, stable instr/pc hold.
// Optional FETCH_TIMEOUT_EN macro adds a stall watchdog that substitutes a NOP on timeout.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_VAL,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_VAL
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_stage,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid,
  output logic        busy,
  output logic        fetch_timeout
);

  fetch_state_t r_state;
  logic [31:0]  r_fetch_addr, r_mem_addr, r_pc, r_instr, r_pend_addr;
  logic         r_mem_req, r_instr_valid, r_busy, r_timeout, r_armed, r_pend_valid;

  logic [31:0]  w_target, w_next_fetch;
  logic         w_in_req, w_accept, w_timeout, w_done;

  assign w_target = word_align(pc_target);
  assign w_in_req = (r_state == FETCH_ST_REQ);
  assign w_accept = fetch_stage && r_armed && !w_in_req;

`ifdef FETCH_TIMEOUT_EN
  instr_fetch_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_accept),
    .i_count  (w_in_req && !mem_ready),
    .o_expired(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  assign w_done = w_in_req && (mem_ready || w_timeout);

  // A redirect arriving in the completion cycle beats any older pending one.
  assign w_next_fetch = pc_load      ? w_target    :
                        r_pend_valid ? r_pend_addr :
                                       r_mem_addr + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= FETCH_ST_IDLE;
      r_fetch_addr  <= RESET_PC;
      r_mem_addr    <= RESET_PC;
      r_pc          <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
      r_mem_req     <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout     <= 1'b0;
      r_armed       <= 1'b1;
      r_pend_valid  <= 1'b0;
      r_pend_addr   <= RESET_PC;
    end else begin
      if (!fetch_stage) begin
        r_armed <= 1'b1;
      end
      case (r_state)
        FETCH_ST_IDLE, FETCH_ST_HOLD: begin
          if (w_accept) begin
            // A redirect in the accept cycle steers this very fetch.
            r_mem_addr    <= pc_load ? w_target : r_fetch_addr;
            r_armed       <= 1'b0;
            r_mem_req     <= 1'b1;
            r_busy        <= 1'b1;
            r_instr_valid <= 1'b0;
            r_state       <= FETCH_ST_REQ;
          end else if (pc_load) begin
            r_fetch_addr <= w_target;
          end
        end
        FETCH_ST_REQ: begin
          if (w_done) begin
            r_instr       <= mem_ready ? mem_rdata : NOP_INSTR;
            r_pc          <= r_mem_addr;
            r_instr_valid <= 1'b1;
            r_mem_req     <= 1'b0;
            r_busy        <= 1'b0;
            r_fetch_addr  <= w_next_fetch;
            r_pend_valid  <= 1'b0;
            r_state       <= FETCH_ST_HOLD;
            if (!mem_ready) begin
              r_timeout <= 1'b1;
            end
          end else if (pc_load) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= w_target;
          end
        end
        default: r_state <= FETCH_ST_IDLE;
      endcase
    end
  end

  assign mem_req       = r_mem_req;
  assign mem_addr      = r_mem_addr;
  assign instr         = r_instr;
  assign pc            = r_pc;
  assign instr_valid   = r_instr_valid;
  assign busy          = r_busy;
  assign fetch_timeout = r_timeout;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; memory returns addr ^ 32'hA5A5_0000.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst, fetch_stage, pc_load, mem_ready;
  logic [31:0] pc_target, mem_rdata;
  logic        mem_req, instr_valid, busy, fetch_timeout;
  logic [31:0] mem_addr, instr, pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

  instr_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_stage  (fetch_stage),
    .pc_load      (pc_load),
    .pc_target    (pc_target),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .instr        (instr),
    .pc           (pc),
    .instr_valid  (instr_valid),
    .busy         (busy),
    .fetch_timeout(fetch_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_stage = 1'b0; pc_load = 1'b0; pc_target = '0; mem_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b exp 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h exp 00000000", mem_addr); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 00000000", pc); end
    checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h exp 00000013", instr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
    checks++; if (busy !== 1'b0 || fetch_timeout !== 1'b0) begin errors++; $display("FAIL reset_busy_to: got %b%b exp 00", busy, fetch_timeout); end
    $display("reset done");
  endtask

  task automatic test_basic_fetch();
    fetch_stage = 1'b1; mem_ready = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || busy !== 1'b1) begin errors++; $display("FAIL f0_issue: got req=%b addr=%h busy=%b exp 1 00000000 1", mem_req, mem_addr, busy); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL f0_valid_early: got %b exp 0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'hA5A5_0000 || pc !== 32'h0) begin errors++; $display("FAIL f0_capture: got v=%b instr=%h pc=%h exp 1 a5a50000 00000000", instr_valid, instr, pc); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL f0_req_drop: got %b exp 0", mem_req); end
    $display("fetch pc=%h instr=%h", pc, instr);
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL f0_no_refetch: got %b exp 0", mem_req); end
    fetch_stage = 1'b0; tick();
    fetch_stage = 1'b1; tick();
    checks++; if (mem_addr !== 32'h4 || mem_req !== 1'b1) begin errors++; $display("FAIL f1_issue: got addr=%h req=%b exp 00000004 1", mem_addr, mem_req); end
    tick();
    checks++; if (instr !== 32'hA5A5_0004 || pc !== 32'h4) begin errors++; $display("FAIL f1_capture: got instr=%h pc=%h exp a5a50004 00000004", instr, pc); end
    $display("fetch pc=%h instr=%h", pc, instr);
  endtask

  task automatic test_wait_states();
    fetch_stage = 1'b0; mem_ready = 1'b0; tick();
    fetch_stage = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8 || instr !== 32'hA5A5_0004 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL wait_hold[%0d]: got req=%b addr=%h instr=%h v=%b exp 1 00000008 a5a50004 0", i, mem_req, mem_addr, instr, instr_valid);
      end
    end
    mem_ready = 1'b1; tick();
    checks++; if (instr !== 32'hA5A5_0008 || pc !== 32'h8 || instr_valid !== 1'b1) begin errors++; $display("FAIL wait_capture: got instr=%h pc=%h v=%b exp a5a50008 00000008 1", instr, pc, instr_valid); end
    $display("fetch pc=%h instr=%h", pc, instr);
  endtask

  task automatic test_redirect();
    fetch_stage = 1'b0; pc_load = 1'b1; pc_target = 32'h0000_0103; tick();
    pc_load = 1'b0;
    checks++; if (pc !== 32'h8 || instr !== 32'hA5A5_0008) begin errors++; $display("FAIL redir_hold_pc: got pc=%h instr=%h exp 00000008 a5a50008", pc, instr); end
    fetch_stage = 1'b1; mem_ready = 1'b0; tick();
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL redir_hold_addr: got %h exp 00000100", mem_addr); end
    pc_load = 1'b1; pc_target = 32'h0000_0200; tick();
    pc_load = 1'b0; mem_ready = 1'b1; tick();
    checks++; if (pc !== 32'h100 || instr !== 32'hA5A5_0100) begin errors++; $display("FAIL redir_req_cur: got pc=%h instr=%h exp 00000100 a5a50100", pc, instr); end
    $display("fetch pc=%h instr=%h", pc, instr);
    fetch_stage = 1'b0; tick();
    fetch_stage = 1'b1; tick();
    checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL redir_req_next: got %h exp 00000200", mem_addr); end
    // redirect coinciding with mem_ready
    pc_load = 1'b1; pc_target = 32'h0000_0304; tick();
    pc_load = 1'b0;
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL redir_same_pc: got %h exp 00000200", pc); end
    fetch_stage = 1'b0; tick();
    fetch_stage = 1'b1; tick();
    checks++; if (mem_addr !== 32'h304) begin errors++; $display("FAIL redir_same_next: got %h exp 00000304", mem_addr); end
    tick();
    $display("fetch pc=%h instr=%h", pc, instr);
  endtask

  task automatic test_wrap();
    fetch_stage = 1'b0; pc_load = 1'b1; pc_target = 32'hFFFF_FFFC; tick();
    pc_load = 1'b0; fetch_stage = 1'b1; tick();
    checks++; if (mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %h exp fffffffc", mem_addr); end
    tick();
    checks++; if (instr !== 32'h5A5A_FFFC || pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_capture: got instr=%h pc=%h exp 5a5afffc fffffffc", instr, pc); end
    $display("fetch pc=%h instr=%h", pc, instr);
    fetch_stage = 1'b0; tick();
    fetch_stage = 1'b1; tick();
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h exp 00000000", mem_addr); end
    tick();
    $display("fetch pc=%h instr=%h", pc, instr);
  endtask

  task automatic test_reset_mid_fetch();
    fetch_stage = 1'b0; mem_ready = 1'b0; tick();
    fetch_stage = 1'b1; tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin errors++; $display("FAIL rmid_issue: got req=%b addr=%h exp 1 00000004", mem_req, mem_addr); end
    fetch_stage = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    checks++; if (mem_req !== 1'b0 || instr !== 32'h13 || instr_valid !== 1'b0 || pc !== 32'h0) begin
      errors++; $display("FAIL rmid_after: got req=%b instr=%h v=%b pc=%h exp 0 00000013 0 00000000", mem_req, instr, instr_valid, pc);
    end
    mem_ready = 1'b1; tick();
    checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h13) begin errors++; $display("FAIL rmid_late_ready: got req=%b v=%b instr=%h exp 0 0 00000013", mem_req, instr_valid, instr); end
    fetch_stage = 1'b1; tick();
    checks++; if (mem_addr !== 32'h0 || mem_req !== 1'b1) begin errors++; $display("FAIL rmid_restart: got addr=%h req=%b exp 00000000 1", mem_addr, mem_req); end
    tick();
    $display("fetch pc=%h instr=%h", pc, instr);
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    fetch_stage = 1'b0; mem_ready = 1'b0; tick();
    fetch_stage = 1'b1; tick();
    for (int i = 0; i < 15; i++) tick();
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || fetch_timeout !== 1'b0) begin errors++; $display("FAIL to_early: got v=%b req=%b to=%b exp 0 1 0", instr_valid, mem_req, fetch_timeout); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h13 || fetch_timeout !== 1'b1 || pc !== 32'h4 || mem_req !== 1'b0) begin
      errors++; $display("FAIL to_fire: got v=%b instr=%h to=%b pc=%h req=%b exp 1 00000013 1 00000004 0", instr_valid, instr, fetch_timeout, pc, mem_req);
    end
    $display("timeout pc=%h instr=%h", pc, instr);
    fetch_stage = 1'b0; mem_ready = 1'b1; tick();
    fetch_stage = 1'b1; tick(); tick();
    checks++; if (pc !== 32'h8 || instr !== 32'hA5A5_0008 || fetch_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got pc=%h instr=%h to=%b exp 00000008 a5a50008 1", pc, instr, fetch_timeout); end
    $display("fetch pc=%h instr=%h", pc, instr);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_redirect();
    test_wrap();
    test_reset_mid_fetch();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
